// File: rtl/detector_sequencer_if.sv
// Bundle of the sequencer's control, pattern and detector-facing signals.
// The master side (test harness / controller) drives start, pattern, len and
// returns the detector's z_in; the sequencer (slave side) drives the rest.
interface detector_sequencer_if;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       z_in;
  logic       w_out;
  logic       busy;
  logic       done;
  logic [3:0] hits;
  logic [2:0] state_out;

  modport master (
    output start, pattern, len, z_in,
    input  w_out, busy, done, hits, state_out
  );

  modport slave (
    input  start, pattern, len, z_in,
    output w_out, busy, done, hits, state_out
  );
endinterface

// File: rtl/detector_sequencer.sv
// Feeds an 8-bit pattern, LSB first, into an external Moore sequence detector
// and counts how many times the detector fires in response.
// A run is: 2 FLUSH cycles of zeros, N SHIFT cycles of pattern bits,
// 1 DRAIN cycle of zero, 1 DONE cycle, then back to IDLE.
//
// Handshake: start is a level request with no acknowledge; it is sampled only
// while in IDLE, and the rising edge that sees start=1 in IDLE accepts it and
// captures pattern/len. busy stays high from the next cycle until the end of
// DONE; done pulses for exactly the DONE cycle.
module detector_sequencer (
  input  logic                 clk,
  input  logic                 reset,
  detector_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FLUSH = 3'b001,
    SHIFT = 3'b010,
    DRAIN = 3'b011,
    DONE  = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hits_q, hits_d;
  logic       prev_shift_q, prev_shift_d;
  logic [3:0] len_eff;

  // Out-of-range lengths (0 and 9..15) run the full 8 bits.
  always_comb begin
    len_eff = bus.len;
    if (bus.len == 4'd0 || bus.len > 4'd8) len_eff = 4'd8;
  end

  // Register update; reset aborts any run immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= 8'd0;
      len_q        <= 4'd0;
      cnt_q        <= 4'd0;
      hits_q       <= 4'd0;
      prev_shift_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hits_q       <= hits_d;
      prev_shift_q <= prev_shift_d;
    end
  end

  // Next-state and datapath. cnt_q counts up through FLUSH and then down
  // through SHIFT as the number of bits still to send.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    hits_d       = hits_q;
    // The detector is Moore with one cycle of delay, so z_in reflects the
    // bit sent in the previous cycle: only credit it when that was SHIFT.
    prev_shift_d = (state_q == SHIFT);
    if (prev_shift_q && bus.z_in) hits_d = hits_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d = bus.pattern;
          len_d   = len_eff;
          cnt_d   = 4'd0;
          hits_d  = 4'd0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = len_q;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SHIFT: begin
        shreg_d = {1'b0, shreg_q[7:1]};
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d   = 4'd0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign bus.w_out     = (state_q == SHIFT) & shreg_q[0];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hits      = hits_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_detector_sequencer.sv
// Directed bench for detector_sequencer: a table of runs (pattern, len,
// per-cycle z_in mask, expected length and hit count) checked cycle by cycle,
// plus hand-written sequences for mid-run reset and start held high.
module tb_detector_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  detector_sequencer_if bus ();

  detector_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [15:0] zmask;     // bit c = z_in during run cycle c (first FLUSH = 1)
    logic        disturb;   // pulse start and change pattern/len mid-SHIFT
    int          exp_n;
    logic [3:0]  exp_hits;
  } vec_t;

  vec_t       vecs[8];
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] p;
    logic [2:0] exp_st;
    logic       exp_w;
    logic [3:0] n;
    p = v.pattern;
    n = v.exp_n[3:0];
    exp_q.delete();
    for (int i = 0; i < v.exp_n; i++) exp_q.push_back(p[i]);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = v.pattern;
    bus.len     = v.len;
    bus.z_in    = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= v.exp_n + 4; c++) begin
      bus.z_in = v.zmask[c];
      if (v.disturb && c == 5) begin
        bus.start   = 1'b1;
        bus.pattern = ~v.pattern;
        bus.len     = 4'd2;
      end
      if (v.disturb && c == 6) bus.start = 1'b0;
      if (c <= 2)                exp_st = 3'd1;
      else if (c <= v.exp_n + 2) exp_st = 3'd2;
      else if (c == v.exp_n + 3) exp_st = 3'd3;
      else                       exp_st = 3'd4;
      chk("state_out", {5'd0, bus.state_out}, {5'd0, exp_st});
      exp_w = 1'b0;
      if (exp_st == 3'd2 && exp_q.size() > 0) exp_w = exp_q.pop_front();
      chk("w_out", {7'd0, bus.w_out}, {7'd0, exp_w});
      chk("busy", {7'd0, bus.busy}, 8'd1);
      chk("done", {7'd0, bus.done}, {7'd0, (c == v.exp_n + 4)});
      if (c == v.exp_n + 4) chk("hits_at_done", {4'd0, bus.hits}, {4'd0, v.exp_hits});
      @(posedge clk); #1;
    end
    bus.z_in = 1'b0;
    chk("idle_state", {5'd0, bus.state_out}, 8'd0);
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);
    chk("idle_done", {7'd0, bus.done}, 8'd0);
    chk("hits_hold", {4'd0, bus.hits}, {4'd0, v.exp_hits});
    chk("run_len", {4'd0, n}, {4'd0, n});
  endtask

  // Main sequence
  initial begin
    logic [2:0] exp_st;
    logic [3:0] exp_h;
    int         m;
    int         done_cnt;
    checks = 0;
    errors = 0;
    bus.start   = 1'b0;
    bus.pattern = 8'd0;
    bus.len     = 4'd0;
    bus.z_in    = 1'b0;

    vecs[0] = '{8'hB5, 4'd8,  16'h0000, 1'b0, 8, 4'd0};
    vecs[1] = '{8'h0F, 4'd4,  16'hFFFF, 1'b0, 4, 4'd4};
    vecs[2] = '{8'h3C, 4'd0,  16'h0000, 1'b0, 8, 4'd0};
    vecs[3] = '{8'hA6, 4'd12, 16'h0A58, 1'b0, 8, 4'd4};
    vecs[4] = '{8'h5A, 4'd6,  16'h0204, 1'b1, 6, 4'd1};
    vecs[5] = '{8'h01, 4'd1,  16'h0018, 1'b0, 1, 4'd1};
    vecs[6] = '{8'hFF, 4'd8,  16'hFFFF, 1'b0, 8, 4'd8};
    vecs[7] = '{8'h81, 4'd9,  16'h1000, 1'b0, 8, 4'd0};

    reset = 1'b1;
    #1;
    chk("rst_state", {5'd0, bus.state_out}, 8'd0);
    chk("rst_w", {7'd0, bus.w_out}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk("rst_hits", {4'd0, bus.hits}, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset asserted during the 3rd SHIFT cycle (run cycle 5).
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.len     = 4'd8;
    bus.z_in    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_state", {5'd0, bus.state_out}, 8'd2);
    chk("pre_rst_hits", {4'd0, bus.hits}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", {5'd0, bus.state_out}, 8'd0);
    chk("mid_rst_w", {7'd0, bus.w_out}, 8'd0);
    chk("mid_rst_hits", {4'd0, bus.hits}, 8'd0);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("mid_rst_done", {7'd0, bus.done}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    bus.z_in = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.state_out !== 3'd0) done_cnt++;
    end
    chk("no_done_after_rst", done_cnt[7:0], 8'd0);

    run_vec(vecs[0]);

    // start held high: three back-to-back len=1 runs, z_in high throughout.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.len     = 4'd1;
    bus.pattern = 8'h01;
    bus.z_in    = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      m = c % 6;
      case (m)
        1, 2:    exp_st = 3'd1;
        3:       exp_st = 3'd2;
        4:       exp_st = 3'd3;
        5:       exp_st = 3'd4;
        default: exp_st = 3'd0;
      endcase
      exp_h = (m == 5 || m == 0) ? 4'd1 : 4'd0;
      chk("b2b_state", {5'd0, bus.state_out}, {5'd0, exp_st});
      chk("b2b_done", {7'd0, bus.done}, {7'd0, (m == 5)});
      chk("b2b_w", {7'd0, bus.w_out}, {7'd0, (m == 3)});
      chk("b2b_hits", {4'd0, bus.hits}, {4'd0, exp_h});
      if (c == 17) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_end_idle", {5'd0, bus.state_out}, 8'd0);
    @(posedge clk); #1;
    chk("b2b_no_4th", {5'd0, bus.state_out}, 8'd0);
    chk("b2b_hits_hold", {4'd0, bus.hits}, 8'd1);
    bus.z_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_sequencer.md
DETECTOR_SEQUENCER -- requirements
Module: detector_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk        input   1  single clock; all state changes on rising edge
  reset      input   1  asynchronous, active-high reset
  start      input   1  request to run one pattern; sampled only in IDLE
  pattern    input   8  bits to feed the detector, LSB first; captured on accepted start
  len        input   4  number of bits to feed; captured on accepted start
  z_in       input   1  detector output (Moore, one cycle after its input bit)
  w_out      output  1  serial bit driven to the detector's w input
  busy       output  1  high in every state except IDLE
  done       output  1  one-cycle pulse at end of run
  hits       output  4  count of z_in assertions credited during the run
  state_out  output  3  current FSM encoding, for debug and LEDs
REQ-002 The block SHALL use the clock clk and the asynchronous active-high reset reset; no other clock or reset.

Function
REQ-003 The FSM SHALL have binary-encoded states IDLE=000, FLUSH=001, SHIFT=010, DRAIN=011, DONE=100; state_out SHALL equal the current encoding.
REQ-004 IDLE: on start=1 the block SHALL capture pattern into an 8-bit shift register and capture the effective length, clear hits to 0, and go to FLUSH next cycle.
REQ-005 Effective length SHALL be len for len 1..8; len=0 or len>8 SHALL be treated as 8.
REQ-006 start SHALL be ignored in every state except IDLE; pattern and len changes after capture SHALL have no effect on the run.
REQ-007 FLUSH SHALL last exactly 2 cycles with w_out=0, forcing the detector to a known state; z_in SHALL be ignored in FLUSH.
REQ-008 SHIFT SHALL last exactly effective-length cycles; in each SHIFT cycle w_out SHALL equal shift-register bit 0, and the register SHALL shift right one bit (zero fill) at the clock edge ending that cycle.
REQ-009 After the last SHIFT cycle the FSM SHALL enter DRAIN for exactly 1 cycle with w_out=0, then DONE for exactly 1 cycle, then IDLE.
REQ-010 w_out SHALL be 0 in IDLE, FLUSH, DRAIN and DONE.
REQ-011 A hit SHALL be credited (hits+1 at the next edge) in any cycle whose previous cycle was SHIFT and z_in=1, i.e. SHIFT cycles 2..N plus the DRAIN cycle; z_in SHALL be ignored in all other cycles.
REQ-012 hits SHALL never exceed 8 (width 4, no wrap possible) and SHALL hold its value from DONE until the next accepted start.
REQ-013 done SHALL be 1 exactly in the DONE cycle and 0 otherwise; busy SHALL be 1 in FLUSH, SHIFT, DRAIN and DONE.
REQ-014 Total run latency from the accepted-start edge to the done pulse SHALL be 2+N+1 cycles, where N is the effective length; done is asserted in cycle 2+N+2 counting the first FLUSH cycle as 1.
REQ-015 start held high continuously SHALL launch a new run on the first IDLE cycle after DONE; back-to-back runs are spaced by exactly one IDLE cycle.

Reset
REQ-016 Asserting reset SHALL immediately (asynchronously) force state IDLE, w_out=0, busy=0, done=0, hits=0, shift register=0 and bit counter=0.
REQ-017 Reset asserted mid-run SHALL abort the run with no done pulse; the first rising edge after reset deasserts SHALL evaluate IDLE normally.

Verification
REQ-018 The bench SHALL cover these scenarios:
  a) Reset, then start with pattern=0xB5, len=8, z_in=0 -> w_out serial 1,0,1,0,1,1,0,1 in SHIFT; done at cycle 12; hits=0.
  b) pattern=0x0F, len=4, z_in=1 for the whole run -> z_in credited in 4 cycles (SHIFT 2..4 + DRAIN); hits=4; FLUSH cycles do not count.
  c) len=0 and len=12 -> both run 8 SHIFT cycles; done at cycle 12.
  d) Pulse start during SHIFT, and change pattern mid-run -> no restart; output bit stream unchanged.
  e) Assert reset during the 3rd SHIFT cycle -> state_out=000, w_out=0, hits=0 immediately; no done pulse.
  f) start held high for 3 runs with len=1 -> done every 6 cycles; one IDLE cycle between runs; hits cleared at each start.
